// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
//   state_t  : divider FSM states (2 bits)
//   min_val  : most-negative two's-complement value for a given width
//   all_ones : all-ones value for a given width
// Both helpers return MAX_W bits; callers narrow with a width cast.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned MAX_W = 128;

  function automatic logic [MAX_W-1:0] min_val(input int unsigned w);
    return MAX_W'(1) << (w - 1);
  endfunction

  // For w == MAX_W the shift yields zero and the subtraction wraps to all ones.
  function automatic logic [MAX_W-1:0] all_ones(input int unsigned w);
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle of the iterative divider.
//   in_valid/in_ready          : request handshake
//   in_signed                  : 1 = DIV/REM, 0 = DIVU/REMU
//   in_dividend/in_divisor     : operands
//   in_tag                     : opaque tag returned with the result
//   out_valid/out_ready        : response handshake (valid held until ready)
//   out_quot/out_rem/out_tag   : results
// master = requester/consumer side, slave = divider side.
interface iter_divider_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quot;
  logic [WIDTH-1:0] out_rem;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_tag
  );

  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_tag
  );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate (combinational).
//   i_neg   : 1 = negate i_val
//   i_val   : input value
//   o_val_c : i_neg ? -i_val : i_val
module div_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val_c
);

  assign o_val_c = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring integer divider, one quotient bit per cycle.
//   clock : clock
//   reset : synchronous, active-high reset
//   flush : drops any in-flight or unconsumed result
//   bus   : request/response bundle (slave side)
// Divide-by-zero and signed overflow complete one cycle after accept;
// normal operations take WIDTH CALC steps plus one FIX cycle.
module iter_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  iter_divider_if.slave bus
);

  localparam int unsigned    CNT_W  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(min_val(WIDTH));
  localparam logic [WIDTH-1:0] ONES_W = WIDTH'(all_ones(WIDTH));

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_div_mag;
  logic               r_s1;
  logic               r_s2;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_quot;
  logic [WIDTH-1:0]   r_out_rem;
  logic [TAG_W-1:0]   r_out_tag;

  logic               w_accept;
  logic               w_s1;
  logic               w_s2;
  logic               w_div_zero;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH:0]     w_diff;

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_quot  = r_out_quot;
  assign bus.out_rem   = r_out_rem;
  assign bus.out_tag   = r_out_tag;

  assign w_accept   = bus.in_valid & (r_state == IDLE);
  assign w_s1       = bus.in_signed & bus.in_dividend[WIDTH-1];
  assign w_s2       = bus.in_signed & bus.in_divisor[WIDTH-1];
  assign w_div_zero = (bus.in_divisor == '0);
  assign w_ovf      = bus.in_signed & (bus.in_dividend == MIN_W) & (bus.in_divisor == ONES_W);

  // Partial remainder (shifted in) minus divisor; MSB set means "does not fit".
  assign w_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_div_mag};

  // Operand magnitudes
  div_sign_fix #(.WIDTH(WIDTH)) u_dvd_mag (.i_neg(w_s1), .i_val(bus.in_dividend), .o_val_c(w_dvd_mag));
  div_sign_fix #(.WIDTH(WIDTH)) u_dvs_mag (.i_neg(w_s2), .i_val(bus.in_divisor),  .o_val_c(w_dvs_mag));

  // Result sign correction: remainder follows dividend, quotient truncates toward zero
  div_sign_fix #(.WIDTH(WIDTH)) u_rem_fix  (.i_neg(r_s1),        .i_val(r_acc[2*WIDTH-1:WIDTH]), .o_val_c(w_rem_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_quot_fix (.i_neg(r_s1 ^ r_s2), .i_val(r_acc[WIDTH-1:0]),       .o_val_c(w_quot_fix));

  // Control FSM, accumulator and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_acc       <= '0;
      r_div_mag   <= '0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_quot  <= '0;
      r_out_rem   <= '0;
      r_out_tag   <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_out_tag <= bus.in_tag;
            r_s1      <= w_s1;
            r_s2      <= w_s2;
            r_div_mag <= w_dvs_mag;
            r_acc     <= {{WIDTH{1'b0}}, w_dvd_mag};
            r_count   <= '0;
            if (w_div_zero) begin
              r_out_quot  <= ONES_W;
              r_out_rem   <= bus.in_dividend;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (w_ovf) begin
              r_out_quot  <= MIN_W;
              r_out_rem   <= '0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (w_diff[WIDTH]) begin
            r_acc <= r_acc << 1;
          end else begin
            r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
          end
          r_count <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_out_quot  <= w_quot_fix;
          r_out_rem   <= w_rem_fix;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider (WIDTH=32 and WIDTH=64 instances).
module tb_iter_divider;

  localparam int unsigned LIMIT = 200;

  logic clock = 1'b0;
  logic reset;
  logic flush;

  always #5 clock = ~clock;

  iter_divider_if #(.WIDTH(32), .TAG_W(5)) bus32 ();
  iter_divider_if #(.WIDTH(64), .TAG_W(5)) bus64 ();

  iter_divider #(.WIDTH(32), .TAG_W(5)) u_dut32 (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus32)
  );

  iter_divider #(.WIDTH(64), .TAG_W(5)) u_dut64 (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus64)
  );

  int checks   = 0;
  int failures = 0;
  int hs32     = 0;
  int hs0      = 0;
  int lat      = 0;

  // Completed response handshakes on the 32-bit instance
  always @(posedge clock) begin
    if (!reset && bus32.out_valid && bus32.out_ready) hs32 <= hs32 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
    @(negedge clock);
    bus32.in_valid    = 1'b1;
    bus32.in_signed   = sgn;
    bus32.in_dividend = a;
    bus32.in_divisor  = b;
    bus32.in_tag      = tag;
    @(posedge clock);
    #1;
    // Scramble inputs after accept: the divider must ignore them
    bus32.in_valid    = 1'b0;
    bus32.in_signed   = ~sgn;
    bus32.in_dividend = ~a;
    bus32.in_divisor  = b ^ 32'h5A5A_A5A5;
    bus32.in_tag      = ~tag;
  endtask

  task automatic wait_valid32(output int l);
    l = 1;
    while (bus32.out_valid !== 1'b1 && l < LIMIT) begin
      @(posedge clock);
      #1;
      l++;
    end
  endtask

  task automatic op32(input string name, input logic sgn, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] tag, input logic [31:0] eq,
                      input logic [31:0] er, input int elat);
    issue32(sgn, a, b, tag);
    wait_valid32(lat);
    chk({name, "_lat"},  64'(lat), 64'(elat));
    chk({name, "_quot"}, 64'(bus32.out_quot), 64'(eq));
    chk({name, "_rem"},  64'(bus32.out_rem), 64'(er));
    chk({name, "_tag"},  64'(bus32.out_tag), 64'(tag));
    @(posedge clock);
    #1;
    chk({name, "_in_ready_after"},  64'(bus32.in_ready), 64'd1);
    chk({name, "_valid_dropped"},   64'(bus32.out_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_signed = 1'b0; bus32.in_dividend = '0;
    bus32.in_divisor = '0; bus32.in_tag = '0; bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_signed = 1'b0; bus64.in_dividend = '0;
    bus64.in_divisor = '0; bus64.in_tag = '0; bus64.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid",    64'(bus32.out_valid), 64'd0);
    chk("rst_quot",     64'(bus32.out_quot), 64'd0);
    chk("rst_rem",      64'(bus32.out_rem), 64'd0);
    chk("rst_tag",      64'(bus32.out_tag), 64'd0);
    chk("rst_in_ready", 64'(bus32.in_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;

    // Normal and special-case operations, out_ready high
    op32("udiv_100_7",    1'b0, 32'd100,        32'd7,          5'd3, 32'd14,         32'd2,          34);
    op32("sdiv_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          5'd4, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  34);
    op32("sdiv_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  5'd5, 32'hFFFF_FFFD,  32'd1,          34);
    op32("sdiv_by0",      1'b1, 32'h1234_5678,  32'd0,          5'd6, 32'hFFFF_FFFF,  32'h1234_5678,  1);
    op32("udiv_by0",      1'b0, 32'd5,          32'd0,          5'd7, 32'hFFFF_FFFF,  32'd5,          1);
    op32("sdiv_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8, 32'h8000_0000,  32'd0,          1);
    op32("udiv_min_ones", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9, 32'd0,          32'h8000_0000,  34);
    op32("sdiv_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd2, 32'd14,         32'hFFFF_FFFE,  34);

    // Backpressure: result held stable while out_ready is low
    @(negedge clock);
    bus32.out_ready = 1'b0;
    issue32(1'b0, 32'hFFFF_FFFF, 32'd1, 5'd10);
    wait_valid32(lat);
    chk("bp_lat", 64'(lat), 64'd34);
    hs0 = hs32;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("bp_hold_valid",    64'(bus32.out_valid), 64'd1);
      chk("bp_hold_quot",     64'(bus32.out_quot), 64'hFFFF_FFFF);
      chk("bp_hold_rem",      64'(bus32.out_rem), 64'd0);
      chk("bp_hold_tag",      64'(bus32.out_tag), 64'd10);
      chk("bp_hold_in_ready", 64'(bus32.in_ready), 64'd0);
    end
    @(negedge clock);
    bus32.out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_valid_drop", 64'(bus32.out_valid), 64'd0);
    chk("bp_one_hs",     64'(hs32 - hs0), 64'd1);
    @(posedge clock);
    #1;
    chk("bp_still_one_hs", 64'(hs32 - hs0), 64'd1);
    chk("bp_in_ready",     64'(bus32.in_ready), 64'd1);

    // Flush at CALC step 10, then a new request two cycles later
    issue32(1'b0, 32'd100, 32'd7, 5'd11);
    repeat (9) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush_valid",    64'(bus32.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus32.in_ready), 64'd1);
    hs0 = hs32;
    @(posedge clock);
    op32("after_flush", 1'b0, 32'd50, 32'd5, 5'd12, 32'd10, 32'd0, 34);
    chk("flush_single_result", 64'(hs32 - hs0), 64'd1);

    // Flush in the same cycle as a request drops the request
    @(negedge clock);
    flush = 1'b1;
    bus32.in_valid = 1'b1; bus32.in_signed = 1'b0;
    bus32.in_dividend = 32'd9; bus32.in_divisor = 32'd0; bus32.in_tag = 5'd1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    bus32.in_valid = 1'b0;
    hs0 = hs32;
    chk("flush_acc_in_ready", 64'(bus32.in_ready), 64'd1);
    repeat (3) @(posedge clock);
    #1;
    chk("flush_acc_no_valid", 64'(bus32.out_valid), 64'd0);
    chk("flush_acc_no_hs",    64'(hs32 - hs0), 64'd0);

    // Flush while a result waits in DONE discards it
    @(negedge clock);
    bus32.out_ready = 1'b0;
    issue32(1'b0, 32'd9, 32'd3, 5'd13);
    wait_valid32(lat);
    chk("done_flush_lat",  64'(lat), 64'd34);
    chk("done_flush_quot", 64'(bus32.out_quot), 64'd3);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    hs0 = hs32;
    chk("done_flush_valid",    64'(bus32.out_valid), 64'd0);
    chk("done_flush_in_ready", 64'(bus32.in_ready), 64'd1);
    @(negedge clock);
    bus32.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("done_flush_no_hs", 64'(hs32 - hs0), 64'd0);

    // Reset mid-CALC clears outputs
    issue32(1'b0, 32'd100, 32'd7, 5'd14);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_rst_valid",    64'(bus32.out_valid), 64'd0);
    chk("mid_rst_quot",     64'(bus32.out_quot), 64'd0);
    chk("mid_rst_rem",      64'(bus32.out_rem), 64'd0);
    chk("mid_rst_tag",      64'(bus32.out_tag), 64'd0);
    chk("mid_rst_in_ready", 64'(bus32.in_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    op32("after_reset", 1'b0, 32'd50, 32'd5, 5'd15, 32'd10, 32'd0, 34);

    // WIDTH=64 signed MIN / 3
    @(negedge clock);
    bus64.in_valid = 1'b1; bus64.in_signed = 1'b1;
    bus64.in_dividend = 64'h8000_0000_0000_0000; bus64.in_divisor = 64'd3; bus64.in_tag = 5'd21;
    @(posedge clock);
    #1;
    bus64.in_valid = 1'b0; bus64.in_dividend = 64'd7; bus64.in_divisor = 64'd0; bus64.in_tag = 5'd0;
    lat = 1;
    while (bus64.out_valid !== 1'b1 && lat < LIMIT) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("w64_lat",  64'(lat), 64'd66);
    chk("w64_quot", bus64.out_quot, 64'hD555_5555_5555_5556);
    chk("w64_rem",  bus64.out_rem, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("w64_tag",  64'(bus64.out_tag), 64'd21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Parametrised radix-2 restoring integer divider for the NPC execute stage; successor to the fixed 32-bit divider.
- Width is configurable, so one block serves RV32 and RV64 (WIDTH=64).
- Adds RISC-V divide-by-zero and signed-overflow fast paths, output backpressure (out_valid/out_ready), pipeline flush, and a passthrough destination tag.
- Produces quotient and remainder together; EXU selects DIV/REM.

Parameters:
- WIDTH, 32, operand/result width in bits; any value ≥4 supported, 32 and 64 required.
- TAG_W, 5, width of the opaque tag carried from request to response (rd index).

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  abort any in-flight or completed-but-unconsumed operation
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request (high only in IDLE)
- in_signed  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
- in_dividend  in  WIDTH  dividend
- in_divisor  in  WIDTH  divisor
- in_tag  in  TAG_W  tag, returned unchanged
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- out_quot  out  WIDTH  quotient
- out_rem  out  WIDTH  remainder
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: state IDLE; out_valid=0; out_quot=0, out_rem=0, out_tag=0; iteration count=0; in_ready=1 (combinational from state).
- FSM states: IDLE, CALC, FIX, DONE. Accept = in_valid & in_ready.
- IDLE:
  - On accept, latch tag, in_signed, and sign flags s1 = in_signed & dividend[MSB], s2 = in_signed & divisor[MSB].
  - Latch magnitudes of both operands (two's-complement negate if the flag is set).
  - Initialise the 2*WIDTH accumulator to {0, |dividend|} and count to 0.
  - Special cases, checked at accept and taking priority over CALC:
    - divisor == 0: quot = all ones, rem = dividend (raw, unsigned view); go directly to DONE. Applies to both signed and unsigned ops.
    - in_signed & dividend == MIN (1 followed by zeros) & divisor == all ones: quot = MIN, rem = 0; go to DONE.
  - Otherwise go to CALC.
- CALC, one step per cycle:
  - diff = acc[2W-1:W-1] - {0, divisor_mag}, (WIDTH+1) bits.
  - If diff is negative: acc <= acc << 1.
  - Else: acc <= {diff[W-1:0], acc[W-2:0], 1}.
  - count increments; after WIDTH steps (count == WIDTH-1 on the step edge) go to FIX.
- FIX, one cycle:
  - rem = s1 ? -acc_hi : acc_hi.
  - quot = (s1 ^ s2) ? -acc_lo : acc_lo.
  - Write out_quot/out_rem; go to DONE.
- DONE: out_valid=1. Outputs and tag stay stable while out_valid & ~out_ready. On out_ready go to IDLE. No new request is accepted in the same cycle (in_ready is low in DONE).
- Latency from the accept edge to out_valid high:
  - Normal operation: WIDTH+2 cycles (WIDTH CALC + FIX + entry to DONE) for WIDTH=32 → 34.
  - Special case: 1 cycle.
- Sign rules:
  - Remainder takes the dividend's sign.
  - Quotient truncates toward zero.
  - Unsigned ops never negate.
- flush:
  - In any state, next state is IDLE and out_valid=0 next cycle; the pending result is discarded.
  - flush has priority over accept: an accept in the same cycle as flush is dropped.
  - Data outputs may hold stale values after flush.
- reset mid-operation: same as flush, plus all outputs return to their reset values.
- Inputs are sampled only on accept; changes on in_* during CALC, FIX or DONE have no effect.

Decomposition:
- Shared package div_pkg holds:
  - state enum {IDLE, CALC, FIX, DONE}, 2 bits;
  - helper constants MIN_VAL(WIDTH) and ALL_ONES(WIDTH) as localparam functions.
- One natural sub-module, div_sign_fix: parametrised WIDTH, combinational conditional two's-complement negate. Instantiated four times: operand magnitude ×2, result fix ×2.
- The FSM and accumulator stay in iter_divider.

Test Plan:
- Unsigned 100 / 7, tag 3, out_ready tied high → out_valid exactly 34 cycles after accept; quot=14, rem=2, tag=3; in_ready high again the next cycle.
- Signed -7 / 2 (0xFFFFFFF9 / 2) → quot=0xFFFFFFFD, rem=0xFFFFFFFF. Then signed 7 / -2 → quot=0xFFFFFFFD, rem=1.
- Divide by zero, signed 0x12345678 / 0 → out_valid 1 cycle after accept; quot=0xFFFFFFFF, rem=0x12345678. Signed 0x80000000 / 0xFFFFFFFF → quot=0x80000000, rem=0, also 1-cycle latency.
- Backpressure on 0xFFFFFFFF / 1 unsigned: hold out_ready low for 5 cycles after out_valid → outputs stable throughout, in_ready=0; on out_ready high, quot=0xFFFFFFFF and rem=0 are consumed once, with one handshake only.
- Assert flush at CALC step 10 → out_valid never asserts for that op; a new 50/5 request accepted 2 cycles later returns quot=10, rem=0 at normal latency. Repeat the abort with reset in place of flush → out_valid=0 and outputs=0 the cycle after reset.
- WIDTH=64 instance: signed 0x8000000000000000 / 3 → quot=0xD555555555555556, rem=0xFFFFFFFFFFFFFFFE, latency 66.
